// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle ADD/SUB/AND/OR/XOR plus an iterative
// shift-add unsigned multiply, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             zero,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL} op_t;

    state_t             state, state_next;
    op_t                op;
    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_flag;
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL);
    assign accept    = in_valid && in_ready;
    assign last_iter = (count == CNT_W'(WIDTH - 1));

    // NOTE: every signal written in an always_comb gets a default first so no path infers a latch.
    always_comb begin
        op = OP_ADD;
        if (opcode == 6'd0) begin
            case (funct)
                6'd2:    op = OP_SUB;
                6'd4:    op = OP_AND;
                6'd5:    op = OP_OR;
                6'd10:   op = OP_XOR;
                6'd24:   op = OP_MUL;
                default: op = OP_ADD;
            endcase
        end else if (opcode == 6'd4) begin
            op = OP_XOR;
        end
    end

    // Top bit of the widened sum is the carry; of the widened difference, the borrow.
    assign sum  = {1'b0, src_a} + {1'b0, src_b};
    assign diff = {1'b0, src_a} - {1'b0, src_b};

    always_comb begin
        alu_res  = sum[WIDTH-1:0];
        alu_flag = sum[WIDTH];
        case (op)
            OP_SUB: begin
                alu_res  = diff[WIDTH-1:0];
                alu_flag = diff[WIDTH];
            end
            OP_AND: begin
                alu_res  = src_a & src_b;
                alu_flag = 1'b0;
            end
            OP_OR: begin
                alu_res  = src_a | src_b;
                alu_flag = 1'b0;
            end
            OP_XOR: begin
                alu_res  = src_a ^ src_b;
                alu_flag = 1'b0;
            end
            default: ;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = (op == OP_MUL) ? S_MUL : S_DONE;
        end else begin
            case (state)
                S_MUL:   if (last_iter) state_next = S_DONE;
                S_DONE:  if (out_ready) state_next = S_IDLE;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= '0;
            flag   <= 1'b0;
            zero   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (accept) begin
            if (op == OP_MUL) begin
                mcand  <= {{WIDTH{1'b0}}, src_a};
                mplier <= src_b;
                acc    <= '0;
                count  <= '0;
            end else begin
                result <= alu_res;
                flag   <= alu_flag;
                zero   <= (alu_res == '0);
            end
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_iter) begin
                result <= acc_next[WIDTH-1:0];
                flag   <= |acc_next[2*WIDTH-1:WIDTH];
                zero   <= (acc_next[WIDTH-1:0] == '0);
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_mc;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n, in_valid, in_ready, out_valid, out_ready, flag, zero, busy;
    logic [5:0]     opcode, funct;
    logic [W-1:0]   src_a, src_b, result;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag(flag), .zero(zero), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode and compute straight from the arithmetic definitions.
    function automatic void ref_op(input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic f, output logic is_mul);
        int kind;
        logic [2*W-1:0] wide;
        wide = '0;
        kind = 0;
        if (opc == 6'd0) begin
            case (fn)
                6'd2:    kind = 1;
                6'd4:    kind = 2;
                6'd5:    kind = 3;
                6'd10:   kind = 4;
                6'd24:   kind = 5;
                default: kind = 0;
            endcase
        end else if (opc == 6'd4) begin
            kind = 4;
        end
        is_mul = (kind == 5);
        f = 1'b0;
        case (kind)
            0: begin
                wide = (2*W)'(a) + (2*W)'(b);
                r = wide[W-1:0];
                f = wide[W];
            end
            1: begin
                r = a - b;
                f = (a < b);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            default: begin
                wide = (2*W)'(a) * (2*W)'(b);
                r = wide[W-1:0];
                f = (wide[2*W-1:W] != '0);
            end
        endcase
    endfunction

    // Model state: an output slot plus at most one multiply in flight.
    logic         m_valid = 1'b0, m_flag = 1'b0, m_zero = 1'b0, m_in_ready = 1'b1;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         p_flag = 1'b0;
    int           m_wait = 0;
    logic         c_rst_n = 1'b0, c_accept = 1'b0, c_out_ready = 1'b0, c_flag = 1'b0, c_mul = 1'b0;
    logic [W-1:0] c_res = '0;

    always @(negedge clk) begin
        if (!c_rst_n) begin
            m_valid = 1'b0; m_wait = 0; m_res = '0; m_flag = 1'b0; m_zero = 1'b0;
        end else begin
            if (m_valid && c_out_ready) m_valid = 1'b0;
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1'b1; m_res = p_res; m_flag = p_flag; m_zero = (p_res == '0);
                end
            end
            if (c_accept) begin
                if (c_mul) begin
                    m_wait = W; p_res = c_res; p_flag = c_flag;
                end else begin
                    m_valid = 1'b1; m_res = c_res; m_flag = c_flag; m_zero = (c_res == '0);
                end
            end
        end
        m_in_ready = (m_wait == 0) && (!m_valid || out_ready);
        if (model_on) begin
            check("model_out_valid", out_valid, m_valid);
            check("model_busy", busy, (m_wait > 0));
            check("model_in_ready", in_ready, m_in_ready);
            if (m_valid) begin
                check("model_result", result, m_res);
                check("model_flag", flag, m_flag);
                check("model_zero", zero, m_zero);
            end
        end
        c_rst_n     = rst_n;
        c_out_ready = out_ready;
        c_accept    = rst_n && in_valid && m_in_ready;
        ref_op(opcode, funct, src_a, src_b, c_res, c_flag, c_mul);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        opcode = opc; funct = fn; src_a = a; src_b = b; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
                return;
            end
        end
        check("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [W-1:0] r, input logic f, input logic z);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check(name, result, r);
                check({name, "_flag"}, flag, f);
                check({name, "_zero"}, zero, z);
                @(posedge clk); #1;
                return;
            end
        end
        check({name, "_timeout"}, out_valid, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic rand_req();
        int sel;
        sel = $urandom_range(0, 11);
        in_valid = 1'b1; opcode = 6'd0; funct = 6'd0;
        case (sel)
            0: funct = 6'd2;
            1: funct = 6'd4;
            2: funct = 6'd5;
            3: funct = 6'd10;
            4: funct = 6'd24;
            5: funct = 6'($urandom);
            6: opcode = 6'd1;
            7: opcode = 6'd4;
            8: opcode = 6'($urandom_range(1, 63));
            default: ;
        endcase
        src_a = pick_operand();
        src_b = pick_operand();
    endtask

    initial begin
        logic [W-1:0] r;
        logic         f, m, took;
        int           lows;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct = '0; src_a = '0; src_b = '0;

        // Pin the reference model to hand-computed values.
        ref_op(6'd0, 6'd24, 32'd1234, 32'd5678, r, f, m);
        check("ref_mul_small", {r, f, m}, {32'd7006652, 1'b0, 1'b1});
        ref_op(6'd0, 6'd2, 32'd3, 32'd5, r, f, m);
        check("ref_sub_borrow", {r, f}, {32'hFFFF_FFFE, 1'b1});
        ref_op(6'd9, 6'd2, 32'hFFFF_FFFF, 32'd2, r, f, m);
        check("ref_unknown_imm_add", {r, f}, {32'd1, 1'b1});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, '0);
        check("rst_flag", flag, 1'b0);
        check("rst_zero", zero, 1'b0);
        model_on = 1'b1;

        // Request held across reset release is accepted on the first edge out of reset.
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = 6'd0; funct = 6'd0; src_a = 32'd5; src_b = 32'd6;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_no_output", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result("add_across_reset", 32'd11, 1'b0, 1'b0);

        // Reset in the middle of a multiply.
        send(6'd0, 6'd24, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midmul_rst_busy", busy, 1'b0);
        check("midmul_rst_out_valid", out_valid, 1'b0);
        check("midmul_rst_in_ready", in_ready, 1'b1);
        check("midmul_rst_result", result, '0);
        @(posedge clk); #1;
        send(6'd0, 6'd0, 32'd1, 32'd1);
        wait_result("add_after_midmul_rst", 32'd2, 1'b0, 1'b0);

        send(6'd0, 6'd0, 32'hFFFF_FFFF, 32'd1);
        wait_result("add_carry", 32'd0, 1'b1, 1'b1);
        send(6'd0, 6'd2, 32'd3, 32'd5);
        wait_result("sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0);
        send(6'd4, 6'd0, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_result("xori", 32'h0F0F_F0F0, 1'b0, 1'b0);

        // Multiply latency and overflow.
        send(6'd0, 6'd24, 32'h1_0000, 32'h1_0000);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) break;
            if (!in_ready) lows++;
        end
        check("mul_in_ready_low_cycles", lows, 32);
        check("mul_ovf_result", result, 32'd0);
        check("mul_ovf_flag", flag, 1'b1);
        check("mul_ovf_zero", zero, 1'b1);
        @(posedge clk); #1;
        send(6'd0, 6'd24, 32'd1234, 32'd5678);
        wait_result("mul_small", 32'd7006652, 1'b0, 1'b0);

        // Back-pressure, then accept the waiting request as the consumer frees up.
        out_ready = 1'b0;
        send(6'd0, 6'd4, 32'h0000_FF00, 32'h0000_0FF0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_stable", result, 32'h0000_0F00);
            check("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; opcode = 6'd0; funct = 6'd0; src_a = 32'd3; src_b = 32'd4;
        @(negedge clk);
        check("bp_pending_not_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", out_valid, 1'b1);
        check("bp_next_result", result, 32'd7);
        @(posedge clk); #1;

        // Streaming adds, one with an unknown immediate opcode.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; opcode = (i == 5) ? 6'd7 : 6'd0; funct = 6'd0;
            src_a = W'(i); src_b = W'(i);
            @(negedge clk);
            check("stream_in_ready", in_ready, 1'b1);
            if (i > 0) check("stream_result", result, W'(2 * (i - 1)));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_result", result, 32'd14);
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (took || !in_valid) begin
                if ($urandom_range(0, 2) != 0) rand_req();
                else begin
                    in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
